lookup_flowktb: RTL and testbench

- Stage directly downstream of the connection-searcher hash lookup. Consumes the candidate flow-key-table index it produces (flowK_idx_valid/flowK_idx_info).
- Buffers each packet's 104-bit flow key from metadata until its index arrives, reads the flow key table at that index, and compares the stored key with the packet key.
- Emits an in-order hit/miss verdict with the connection index.

---
 rtl/lookup_flowktb.sv | 185 ++++++++++++++++++
 tb/tb_lookup_flowktb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_flowktb.sv
// lookup_flowktb: flow-key-table lookup stage behind the hash searcher.
// Buffers each packet's flow key until its candidate index arrives. It then
// reads the flow key table at that index and compares the stored key with the
// packet key. Verdicts come out in order, four cycles after the index.
// Optional hit/miss counters are enabled by defining LOOKUP_FLOWKTB_CNT_EN.
module lookup_flowktb #(
  parameter int w_meta          = 104,
  parameter int w_key           = 104,
  parameter int w_flowKIdx_info = 16,
  parameter int d_flowKTb       = 10,
  parameter int w_flowKTb       = 105,
  parameter int d_keyFifo       = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       metadata_in_valid,
  input  logic [w_meta-1:0]          metadata_in,
  input  logic                       flowK_idx_valid,
  input  logic [w_flowKIdx_info-1:0] flowK_idx_info,
  output logic                       rdValid_flowKTb,
  output logic [d_flowKTb-1:0]       idx_flowKTb,
  input  logic [w_flowKTb-1:0]       ctx_flowKTb,
  output logic                       result_valid,
  output logic                       result_hit,
  output logic [w_flowKIdx_info-1:0] result_idx,
  output logic [w_key-1:0]           result_key,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt
);

  localparam int DEPTH = 1 << d_keyFifo;

  logic [w_key-1:0]     key_mem [DEPTH];
  logic [d_keyFifo-1:0] wr_ptr;
  logic [d_keyFifo-1:0] rd_ptr;
  logic [d_keyFifo:0]   count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic [w_key-1:0] head_key;

  logic                       s1_valid, s2_valid, s3_valid;
  logic [w_flowKIdx_info-1:0] s1_idx, s2_idx, s3_idx;
  logic [w_key-1:0]           s1_key, s2_key, s3_key;
  logic                       s1_uf, s2_uf, s3_uf;
  logic                       s1_zero, s2_zero, s3_zero;
  logic                       s3_hit;

  // FIFO status and accept decisions; a full FIFO still accepts a push when a pop frees a slot
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = count[d_keyFifo];
    do_pop     = flowK_idx_valid && !fifo_empty;
    do_push    = metadata_in_valid && (!fifo_full || do_pop);
    head_key   = fifo_empty ? '0 : key_mem[rd_ptr];
  end

  // Key storage; contents need no reset since pointers decide what is live
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      key_mem[wr_ptr] <= metadata_in[w_key-1:0];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags for pushes into a full FIFO and indices with no waiting key
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (metadata_in_valid && fifo_full && !do_pop) err_overflow  <= 1'b1;
      if (flowK_idx_valid && fifo_empty)            err_underflow <= 1'b1;
    end
  end

  // Stage 1: issue the table read and capture key, index and flags beside it
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_key   <= '0;
      s1_uf    <= 1'b0;
      s1_zero  <= 1'b0;
    end else begin
      s1_valid <= flowK_idx_valid;
      if (flowK_idx_valid) begin
        s1_idx  <= flowK_idx_info;
        s1_key  <= head_key;
        s1_uf   <= fifo_empty;
        s1_zero <= (flowK_idx_info == '0);
      end
    end
  end

  // Stages 2 and 3: carry the packet context while the table read is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_key   <= '0;
      s2_uf    <= 1'b0;
      s2_zero  <= 1'b0;
      s3_valid <= 1'b0;
      s3_idx   <= '0;
      s3_key   <= '0;
      s3_uf    <= 1'b0;
      s3_zero  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_key   <= s1_key;
      s2_uf    <= s1_uf;
      s2_zero  <= s1_zero;
      s3_valid <= s2_valid;
      s3_idx   <= s2_idx;
      s3_key   <= s2_key;
      s3_uf    <= s2_uf;
      s3_zero  <= s2_zero;
    end
  end

  // Hit needs a nonzero index, a valid entry, an equal key and a real (non-underflow) key
  always_comb begin
    s3_hit = !s3_zero && ctx_flowKTb[w_key] &&
             (ctx_flowKTb[w_key-1:0] == s3_key) && !s3_uf;
  end

  // Result register; verdict fields hold their last values between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_idx   <= '0;
      result_key   <= '0;
    end else begin
      result_valid <= s3_valid;
      if (s3_valid) begin
        result_hit <= s3_hit;
        result_idx <= s3_hit ? s3_idx : '0;
        result_key <= s3_key;
      end
    end
  end

  assign rdValid_flowKTb = s1_valid;
  assign idx_flowKTb     = s1_idx[d_flowKTb-1:0];

`ifdef LOOKUP_FLOWKTB_CNT_EN
  // Wrapping hit/miss counters advanced on every emitted verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (result_valid) begin
      if (result_hit) hit_cnt  <= hit_cnt + 32'd1;
      else            miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_lookup_flowktb.sv
// tb_lookup_flowktb: directed test of lookup_flowktb against a queue-based
// model, with a two-cycle flow key table responder. The counter checks follow
// LOOKUP_FLOWKTB_CNT_EN.
module tb_lookup_flowktb;

  logic         clk;
  logic         reset;
  logic         metadata_in_valid;
  logic [103:0] metadata_in;
  logic         flowK_idx_valid;
  logic [15:0]  flowK_idx_info;
  logic         rdValid_flowKTb;
  logic [9:0]   idx_flowKTb;
  logic [104:0] ctx_flowKTb;
  logic         result_valid;
  logic         result_hit;
  logic [15:0]  result_idx;
  logic [103:0] result_key;
  logic         err_overflow;
  logic         err_underflow;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  lookup_flowktb dut (
    .clk               (clk),
    .reset             (reset),
    .metadata_in_valid (metadata_in_valid),
    .metadata_in       (metadata_in),
    .flowK_idx_valid   (flowK_idx_valid),
    .flowK_idx_info    (flowK_idx_info),
    .rdValid_flowKTb   (rdValid_flowKTb),
    .idx_flowKTb       (idx_flowKTb),
    .ctx_flowKTb       (ctx_flowKTb),
    .result_valid      (result_valid),
    .result_hit        (result_hit),
    .result_idx        (result_idx),
    .result_key        (result_key),
    .err_overflow      (err_overflow),
    .err_underflow     (err_underflow),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
  );

  localparam logic [103:0] K = 104'h11_0050_1F90_0A000002_0A000001;

  typedef struct {
    int           due;
    logic         hit;
    logic [15:0]  idx;
    logic [103:0] key;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [104:0] tbl [1024];
  logic [104:0] ctx_p1, ctx_p2;

  logic [103:0] fifo_q [$];
  res_t         res_q  [$];
  res_t         r;
  int           edges = 0;
  logic         m_init = 1'b0;
  logic         m_ovf = 1'b0, m_udf = 1'b0;
  logic [31:0]  m_hit_cnt = '0, m_miss_cnt = '0;
  logic         exp_valid = 1'b0, exp_hit = 1'b0;
  logic [15:0]  exp_idx = '0;
  logic [103:0] exp_key = '0;
  logic         exp_rd = 1'b0;
  logic [9:0]   exp_rdidx = '0;
  logic [103:0] m_key;
  logic         m_uf;
  logic [104:0] m_ent;
  logic [103:0] keys [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flow key table responder: data appears two cycles after the read strobe
  always @(posedge clk) begin
    ctx_p1 <= rdValid_flowKTb ? tbl[idx_flowKTb] : '0;
    ctx_p2 <= ctx_p1;
  end
  assign ctx_flowKTb = ctx_p2;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, act, exp, edges);
    end
  endtask

  // Reference model: key queue plus scheduled verdicts, updated on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
      res_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      m_hit_cnt = '0; m_miss_cnt = '0;
      exp_valid = 1'b0; exp_hit = 1'b0; exp_idx = '0; exp_key = '0;
      exp_rd = 1'b0; exp_rdidx = '0;
      m_init = 1'b1;
    end else begin
      if (exp_valid) begin
        if (exp_hit) m_hit_cnt = m_hit_cnt + 32'd1;
        else         m_miss_cnt = m_miss_cnt + 32'd1;
      end
      exp_valid = 1'b0;
      if (res_q.size() > 0 && res_q[0].due == edges) begin
        r = res_q.pop_front();
        exp_valid = 1'b1;
        exp_hit   = r.hit;
        exp_idx   = r.idx;
        exp_key   = r.key;
      end
      exp_rd = flowK_idx_valid;
      if (flowK_idx_valid) begin
        exp_rdidx = flowK_idx_info[9:0];
        if (fifo_q.size() == 0) begin
          m_uf = 1'b1; m_key = '0; m_udf = 1'b1;
        end else begin
          m_uf = 1'b0; m_key = fifo_q.pop_front();
        end
        m_ent   = tbl[flowK_idx_info[9:0]];
        r.due   = edges + 3;
        r.hit   = (flowK_idx_info != 0) && m_ent[104] && (m_ent[103:0] == m_key) && !m_uf;
        r.idx   = r.hit ? flowK_idx_info : 16'h0;
        r.key   = m_key;
        res_q.push_back(r);
      end
      if (metadata_in_valid) begin
        if (fifo_q.size() < 8) fifo_q.push_back(metadata_in);
        else                   m_ovf = 1'b1;
      end
    end
    edges++;
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("result_valid", 128'(result_valid), 128'(exp_valid));
      checkOutput("result_hit", 128'(result_hit), 128'(exp_hit));
      checkOutput("result_idx", 128'(result_idx), 128'(exp_idx));
      checkOutput("result_key", 128'(result_key), 128'(exp_key));
      checkOutput("rdValid", 128'(rdValid_flowKTb), 128'(exp_rd));
      if (exp_rd) checkOutput("idx_flowKTb", 128'(idx_flowKTb), 128'(exp_rdidx));
      checkOutput("err_overflow", 128'(err_overflow), 128'(m_ovf));
      checkOutput("err_underflow", 128'(err_underflow), 128'(m_udf));
`ifdef LOOKUP_FLOWKTB_CNT_EN
      checkOutput("hit_cnt", 128'(hit_cnt), 128'(m_hit_cnt));
      checkOutput("miss_cnt", 128'(miss_cnt), 128'(m_miss_cnt));
`else
      checkOutput("hit_cnt", 128'(hit_cnt), 128'(0));
      checkOutput("miss_cnt", 128'(miss_cnt), 128'(0));
`endif
    end
  end

  task automatic applyStimulus(input logic mv, input logic [103:0] md,
                               input logic iv, input logic [15:0] ix);
    @(negedge clk);
    metadata_in_valid = mv;
    metadata_in       = md;
    flowK_idx_valid   = iv;
    flowK_idx_info    = ix;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    metadata_in_valid = 1'b0; metadata_in = '0;
    flowK_idx_valid = 1'b0; flowK_idx_info = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    metadata_in_valid = 1'b0; metadata_in = '0;
    flowK_idx_valid = 1'b0; flowK_idx_info = '0;
    for (int i = 0; i < 1024; i++) tbl[i] = '0;
    for (int i = 0; i < 10; i++) keys[i] = K ^ (104'(i + 1) << 40);
    applyReset();
    checkOutput("reset result_valid", 128'(result_valid), 128'(0));
    checkOutput("reset rdValid", 128'(rdValid_flowKTb), 128'(0));

    // Single hit at index 5
    tbl[5] = {1'b1, K};
    applyStimulus(1'b1, K, 1'b0, '0);
    idle(3);
    applyStimulus(1'b0, '0, 1'b1, 16'h0005);
    idle(4);
    checkOutput("hit valid", 128'(result_valid), 128'(1));
    checkOutput("hit flag", 128'(result_hit), 128'(1));
    checkOutput("hit idx", 128'(result_idx), 128'(16'h0005));
    checkOutput("hit key", 128'(result_key), 128'(K));

    // Index 0 with a matching valid entry is still a miss, but a read is issued
    tbl[0] = {1'b1, keys[0]};
    applyStimulus(1'b1, keys[0], 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 16'h0000);
    idle(1);
    checkOutput("idx0 rdValid", 128'(rdValid_flowKTb), 128'(1));
    checkOutput("idx0 address", 128'(idx_flowKTb), 128'(0));
    idle(3);
    checkOutput("idx0 valid", 128'(result_valid), 128'(1));
    checkOutput("idx0 hit", 128'(result_hit), 128'(0));
    checkOutput("idx0 idx", 128'(result_idx), 128'(0));

    // Key mismatch and invalid entry
    tbl[6] = {1'b1, keys[1] ^ 104'h1};
    tbl[7] = {1'b0, keys[1]};
    applyStimulus(1'b1, keys[1], 1'b0, '0);
    applyStimulus(1'b1, keys[1], 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 16'h0006);
    applyStimulus(1'b0, '0, 1'b1, 16'h0007);
    idle(4);
    checkOutput("invalid entry hit", 128'(result_hit), 128'(0));
    checkOutput("invalid entry idx", 128'(result_idx), 128'(0));

    // Eight back-to-back packets, alternating hit/miss, upper index bits carried
    applyReset();
    for (int i = 0; i < 8; i++) begin
      tbl[16 + i] = (i % 2 == 0) ? {1'b1, keys[i]} : {1'b1, keys[i] ^ 104'h80};
      applyStimulus(1'b1, keys[i], 1'b0, '0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 16'hA410 + 16'(i));
    idle(5);
    checkOutput("b2b err_overflow", 128'(err_overflow), 128'(0));
    checkOutput("b2b err_underflow", 128'(err_underflow), 128'(0));
`ifdef LOOKUP_FLOWKTB_CNT_EN
    checkOutput("b2b hit_cnt", 128'(hit_cnt), 128'(4));
    checkOutput("b2b miss_cnt", 128'(miss_cnt), 128'(4));
`endif

    // Overflow: nine pushes, the ninth dropped; then push+pop while full
    applyReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, keys[i], 1'b0, '0);
    idle(1);
    checkOutput("overflow flag", 128'(err_overflow), 128'(1));
    for (int i = 0; i < 8; i++) tbl[32 + i] = {1'b1, keys[i]};
    tbl[40] = {1'b1, keys[9]};
    applyStimulus(1'b1, keys[9], 1'b1, 16'h0020);
    for (int i = 1; i < 9; i++) applyStimulus(1'b0, '0, 1'b1, 16'h0020 + 16'(i));
    idle(4);
    checkOutput("full push+pop key hit", 128'(result_hit), 128'(1));
    checkOutput("full push+pop key", 128'(result_key), 128'(keys[9]));

    // Underflow: index on empty FIFO with a same-cycle push that must not bypass
    tbl[48] = {1'b1, 104'h0};
    tbl[49] = {1'b1, keys[2]};
    applyStimulus(1'b1, keys[2], 1'b1, 16'h0030);
    applyStimulus(1'b0, '0, 1'b1, 16'h0031);
    idle(3);
    checkOutput("underflow hit", 128'(result_hit), 128'(0));
    checkOutput("underflow key", 128'(result_key), 128'(0));
    checkOutput("underflow flag", 128'(err_underflow), 128'(1));
    idle(1);
    checkOutput("after underflow hit", 128'(result_hit), 128'(1));

    // Reset two cycles after an index flushes it
    tbl[65] = {1'b1, keys[3]};
    applyStimulus(1'b1, keys[3], 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 16'h0041);
    idle(1);
    @(negedge clk);
    reset = 1'b1;
    metadata_in_valid = 1'b0; flowK_idx_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush result_valid", 128'(result_valid), 128'(0));
    checkOutput("flush result_key", 128'(result_key), 128'(0));
    checkOutput("flush err_underflow", 128'(err_underflow), 128'(0));
    reset = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
